// File: rtl/mmio_led_port.sv
// Memory-mapped LED port: LED data, display control, tick period and a
// free-running cycle counter behind a 16-byte window on the data bus.
module mmio_led_port #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_7F00,
  parameter logic [23:0] DEFAULT_PERIOD = 24'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [7:0]  led
);

  localparam logic [1:0] OFF_LED = 2'd0;
  localparam logic [1:0] OFF_CTL = 2'd1;
  localparam logic [1:0] OFF_PER = 2'd2;
  localparam logic [1:0] OFF_CYC = 2'd3;

  logic [7:0]  r_led_data;
  logic [1:0]  r_ctrl;
  logic [23:0] r_period;
  logic [31:0] r_cycle;
  logic [23:0] r_tick_cnt;
  logic        r_phase;
  logic [7:0]  r_led;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic [1:0]  w_off;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_led;
  logic        w_wr_ctl;
  logic        w_wr_per;
  logic        w_wr_cyc;
  logic [23:0] w_eff;
  logic        w_tick;
  logic        w_blank;
  logic [31:0] w_rd_val;
  logic [7:0]  w_led_nxt;
  logic        w_unused;

  assign w_off    = addr[3:2];
  assign w_hit    = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr     = we && w_hit;
  assign w_rd     = re && w_hit;
  assign w_wr_led = w_wr && (w_off == OFF_LED);
  assign w_wr_ctl = w_wr && (w_off == OFF_CTL);
  assign w_wr_per = w_wr && (w_off == OFF_PER);
  assign w_wr_cyc = w_wr && (w_off == OFF_CYC);
  assign w_unused = ^{addr[1:0], wdata[31:24], BASE_ADDR[3:0]};

  // PERIOD of zero behaves as one: tick every cycle
  assign w_eff   = (r_period == 24'd0) ? 24'd1 : r_period;
  assign w_tick  = (r_ctrl != 2'b00) && (r_tick_cnt == w_eff - 24'd1);
  assign w_blank = (r_ctrl == 2'b01) && r_phase;

  always_comb begin
    w_rd_val = 32'd0;
    unique case (w_off)
      OFF_LED: w_rd_val = {24'd0, r_led_data};
      OFF_CTL: w_rd_val = {30'd0, r_ctrl};
      OFF_PER: w_rd_val = {8'd0, r_period};
      OFF_CYC: w_rd_val = r_cycle;
    endcase
  end

  always_comb begin
    w_led_nxt = r_led_data;
    unique case (1'b1)
      w_blank: w_led_nxt = 8'h00;
      default: w_led_nxt = r_led_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led_data <= 8'd0;
      r_ctrl     <= 2'd0;
      r_period   <= DEFAULT_PERIOD;
      r_cycle    <= 32'd0;
      r_tick_cnt <= 24'd0;
      r_phase    <= 1'b0;
      r_led      <= 8'd0;
      r_rdata    <= 32'd0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rd_val;

      r_cycle <= w_wr_cyc ? 32'd0 : r_cycle + 32'd1;

      if (w_wr_ctl || w_wr_per) begin
        r_tick_cnt <= 24'd0;
        r_phase    <= 1'b0;
      end else if (r_ctrl == 2'b00) begin
        r_tick_cnt <= 24'd0;
        r_phase    <= 1'b0;
      end else if (w_tick) begin
        r_tick_cnt <= 24'd0;
        if (!r_ctrl[1]) r_phase <= ~r_phase;
      end else begin
        r_tick_cnt <= r_tick_cnt + 24'd1;
      end

      // a CPU store to LED_DATA drops a coincident rotate
      if (w_wr_led)
        r_led_data <= wdata[7:0];
      else if (w_tick && r_ctrl[1])
        r_led_data <= {r_led_data[6:0], r_led_data[7]};

      if (w_wr_ctl) r_ctrl   <= wdata[1:0];
      if (w_wr_per) r_period <= wdata[23:0];

      r_led <= w_led_nxt;
    end
  end

  assign hit    = w_hit;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign led    = r_led;

endmodule

// File: tb/tb_mmio_led_port.sv
// Directed bench for mmio_led_port: register access, display modes,
// cycle counter, address miss and reset behaviour.
module tb_mmio_led_port;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        hit;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  led;

  int n_chk;
  int n_fail;

  mmio_led_port dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .hit    (hit),
    .rdata  (rdata),
    .rvalid (rvalid),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d,
                        output logic v, output logic h);
    addr = a;
    re   = 1'b1;
    #1;
    h    = hit;
    step();
    re   = 1'b0;
    d    = rdata;
    v    = rvalid;
  endtask

  logic [31:0] d;
  logic        v;
  logic        h;
  logic [7:0]  exp8;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    addr   = 32'd0;
    wdata  = 32'd0;
    we     = 1'b0;
    re     = 1'b0;
    steps(3);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    step();

    // static write and readback
    bus_wr(BASE + 32'h0, 32'hFFFF_FFA5);
    chk("st_led_lag", {24'd0, led}, 32'h00);
    step();
    chk("st_led", {24'd0, led}, 32'hA5);
    bus_rd(BASE + 32'h0, d, v, h);
    chk("st_rd_v", {31'd0, v}, 32'd1);
    chk("st_rd_d", d, 32'h0000_00A5);
    step();
    chk("st_rv_drop", {31'd0, rvalid}, 32'd0);

    // write and read on the same cycle returns the old value
    addr  = BASE + 32'h3;
    wdata = 32'h5A;
    we    = 1'b1;
    re    = 1'b1;
    step();
    we    = 1'b0;
    re    = 1'b0;
    chk("rw_old", rdata, 32'hA5);
    bus_rd(BASE, d, v, h);
    chk("rw_new", d, 32'h5A);

    // rotate with PERIOD=4
    bus_wr(BASE + 32'h0, 32'h81);
    bus_wr(BASE + 32'h8, 32'd4);
    bus_wr(BASE + 32'h4, 32'd2);
    steps(4);
    chk("rot_led0", {24'd0, led}, 32'h81);
    step();
    chk("rot_led1", {24'd0, led}, 32'h03);
    bus_rd(BASE + 32'h0, d, v, h);
    chk("rot_rd1", d, 32'h03);
    steps(2);
    chk("rot_led1b", {24'd0, led}, 32'h03);
    step();
    chk("rot_led2", {24'd0, led}, 32'h06);
    bus_wr(BASE + 32'h4, 32'd0);

    // blink with PERIOD=3
    bus_wr(BASE + 32'h0, 32'hFF);
    bus_wr(BASE + 32'h8, 32'd3);
    bus_wr(BASE + 32'h4, 32'd1);
    steps(3);
    chk("blk_on0", {24'd0, led}, 32'hFF);
    step();
    chk("blk_off0", {24'd0, led}, 32'h00);
    steps(2);
    chk("blk_off0b", {24'd0, led}, 32'h00);
    step();
    chk("blk_on1", {24'd0, led}, 32'hFF);
    steps(3);
    chk("blk_off1", {24'd0, led}, 32'h00);
    bus_wr(BASE + 32'h4, 32'd0);
    chk("blk_stop_lag", {24'd0, led}, 32'h00);
    step();
    chk("blk_stop", {24'd0, led}, 32'hFF);

    // PERIOD=0 rotates every cycle, including the 0x80 -> 0x01 wrap
    bus_wr(BASE + 32'h0, 32'h01);
    bus_wr(BASE + 32'h8, 32'd0);
    bus_wr(BASE + 32'h4, 32'd2);
    exp8 = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("p0_rot%0d", k), {24'd0, led}, {24'd0, exp8});
      exp8 = {exp8[6:0], exp8[7]};
    end
    // store on a rotate tick wins over the rotate
    bus_wr(BASE + 32'h0, 32'h3C);
    step();
    chk("tick_store", {24'd0, led}, 32'h3C);
    bus_wr(BASE + 32'h4, 32'd0);

    // cycle counter clear and count
    bus_wr(BASE + 32'hC, 32'hDEAD_BEEF);
    steps(5);
    bus_rd(BASE + 32'hC, d, v, h);
    chk("cyc_v", {31'd0, v}, 32'd1);
    chk("cyc_val", d, 32'd5);

    // miss above the window
    bus_rd(BASE + 32'h10, d, v, h);
    chk("miss_hit", {31'd0, h}, 32'd0);
    chk("miss_rv", {31'd0, v}, 32'd0);
    chk("miss_rd", d, 32'd5);
    addr = BASE + 32'hF;
    #1;
    chk("hit_top", {31'd0, hit}, 32'd1);

    // reset during blink with a load in flight
    bus_wr(BASE + 32'h0, 32'hFF);
    bus_wr(BASE + 32'h8, 32'd3);
    bus_wr(BASE + 32'h4, 32'd1);
    step();
    addr = BASE + 32'h0;
    re   = 1'b1;
    rst  = 1'b0;
    step();
    re   = 1'b0;
    rst  = 1'b1;
    chk("rr_rv", {31'd0, rvalid}, 32'd0);
    chk("rr_led", {24'd0, led}, 32'd0);
    bus_rd(BASE + 32'h4, d, v, h);
    chk("rr_ctrl", d, 32'd0);
    bus_rd(BASE + 32'h8, d, v, h);
    chk("rr_per", d, 32'd50);
    bus_rd(BASE + 32'h0, d, v, h);
    chk("rr_data", d, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
